dice_result_capture: RTL and testbench

DICE_RESULT_CAPTURE -- requirements
Module: dice_result_capture

---
 rtl/dice_result_capture_if.sv | 33 +++
 rtl/dice_result_capture.sv | 125 ++++++++++++
 tb/tb_dice_result_capture.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dice_result_capture_if.sv
// Dice result capture bus.
// Groups the roll inputs (button, throw) and all capture outputs so the
// capture block and its driver share one bundle.
//   button       : roll button, high while the dice is rolling
//   throw        : dice counter value, legal range 1..6
//   result       : last captured legal throw, 0 = none yet
//   result_valid : one-cycle pulse when result updates
//   leds         : registered pip pattern of result
//   total        : saturating sum of captured results
//   roll_count   : wrapping count of captured results
//   double_flag  : latest capture repeated the previous one
//   err          : sticky, an illegal throw was captured
interface dice_result_capture_if;
    logic       button;
    logic [2:0] throw;
    logic [2:0] result;
    logic       result_valid;
    logic [6:0] leds;
    logic [7:0] total;
    logic [7:0] roll_count;
    logic       double_flag;
    logic       err;

    modport master (
        output button, throw,
        input  result, result_valid, leds, total, roll_count, double_flag, err
    );

    modport slave (
        input  button, throw,
        output result, result_valid, leds, total, roll_count, double_flag, err
    );
endinterface

// File: rtl/dice_result_capture.sv
// Dice result capture.
// Watches the roll button; when it is released after a roll, the frozen
// dice value is captured, shown on the pip LEDs and accumulated.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : dice_result_capture_if.slave (button/throw in, results out)
//
// state   | meaning
// IDLE    | waiting for the button to go high
// ROLLING | button held, dice counter running
// CAPTURE | one cycle after release; captured value is on the outputs
module dice_result_capture (
    input  logic                  clk,
    input  logic                  rst,
    dice_result_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       button_d;
    logic       fall;
    logic       capture;
    logic       legal;
    logic [8:0] sum_wide;
    logic [7:0] total_sat;
    logic [2:0] result_nxt;
    logic [6:0] leds_nxt;

    logic [2:0] result_q;
    logic       result_valid_q;
    logic [6:0] leds_q;
    logic [7:0] total_q;
    logic [7:0] roll_count_q;
    logic       double_flag_q;
    logic       err_q;

    assign fall  = button_d & ~bus.button;
    assign legal = (bus.throw != 3'd0) && (bus.throw != 3'd7);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.button) state_nxt = ROLLING;
            end
            ROLLING: begin
                if (fall) begin
                    state_nxt = CAPTURE;
                    capture   = 1'b1;
                end
            end
            CAPTURE: begin
                state_nxt = bus.button ? ROLLING : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ninth bit of the sum flags overflow past 255.
    assign sum_wide  = {1'b0, total_q} + {6'b0, bus.throw};
    assign total_sat = sum_wide[8] ? 8'hFF : sum_wide[7:0];

    assign result_nxt = (capture && legal) ? bus.throw : result_q;

    // LEDs are computed from the next state/result so they change on the
    // same edge as result; blank while rolling or before the first result.
    always_comb begin
        leds_nxt = 7'h00;
        if (state_nxt != ROLLING) begin
            case (result_nxt)
                3'd1:    leds_nxt = 7'h01;
                3'd2:    leds_nxt = 7'h42;
                3'd3:    leds_nxt = 7'h43;
                3'd4:    leds_nxt = 7'h66;
                3'd5:    leds_nxt = 7'h67;
                3'd6:    leds_nxt = 7'h7E;
                default: leds_nxt = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            button_d       <= 1'b0;
            result_q       <= 3'd0;
            result_valid_q <= 1'b0;
            leds_q         <= 7'h00;
            total_q        <= 8'd0;
            roll_count_q   <= 8'd0;
            double_flag_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state          <= state_nxt;
            button_d       <= bus.button;
            result_valid_q <= capture && legal;
            leds_q         <= leds_nxt;
            if (capture) begin
                if (legal) begin
                    result_q      <= bus.throw;
                    total_q       <= total_sat;
                    roll_count_q  <= roll_count_q + 8'd1;
                    double_flag_q <= (roll_count_q != 8'd0) && (bus.throw == result_q);
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.leds         = leds_q;
    assign bus.total        = total_q;
    assign bus.roll_count   = roll_count_q;
    assign bus.double_flag  = double_flag_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_dice_result_capture.sv
module tb_dice_result_capture;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    dice_result_capture_if bus ();

    dice_result_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a capture happens on any edge where the button was
    // sampled high on the previous (non-reset) edge and is low now.
    int m_prev_btn = 0;
    int m_result = 0, m_valid = 0, m_leds = 0, m_total = 0;
    int m_count = 0, m_double = 0, m_err = 0;
    int pips [8] = '{0, 'h01, 'h42, 'h43, 'h66, 'h67, 'h7E, 0};

    always @(posedge clk) begin
        int t;
        t = int'(bus.throw);
        m_valid = 0;
        if (rst) begin
            m_prev_btn = 0; m_result = 0; m_total = 0;
            m_count = 0; m_double = 0; m_err = 0;
        end else begin
            if (m_prev_btn == 1 && bus.button == 1'b0) begin
                if (t >= 1 && t <= 6) begin
                    m_double = (m_count != 0 && t == m_result) ? 1 : 0;
                    m_result = t;
                    m_total  = (m_total + t > 255) ? 255 : m_total + t;
                    m_count  = (m_count + 1) % 256;
                    m_valid  = 1;
                end else begin
                    m_err = 1;
                end
            end
            m_prev_btn = (bus.button == 1'b1) ? 1 : 0;
        end
        m_leds = (m_prev_btn == 1 || m_result == 0) ? 0 : pips[m_result];
        #1;
        check("result",       int'(bus.result),       m_result);
        check("result_valid", int'(bus.result_valid), m_valid);
        check("leds",         int'(bus.leds),         m_leds);
        check("total",        int'(bus.total),        m_total);
        check("roll_count",   int'(bus.roll_count),   m_count);
        check("double_flag",  int'(bus.double_flag),  m_double);
        check("err",          int'(bus.err),          m_err);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.button = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Returns at the falling edge inside the CAPTURE cycle.
    task automatic roll(input logic [2:0] v);
        bus.button = 1'b1;
        tick();
        bus.button = 1'b0;
        bus.throw  = v;
        tick();
    endtask

    initial begin
        rst = 1'b1; bus.button = 1'b1; bus.throw = 3'd3;
        tick(3);
        check("rst_result", int'(bus.result), 0);
        check("rst_leds",   int'(bus.leds),   0);
        check("rst_total",  int'(bus.total),  0);
        check("rst_err",    int'(bus.err),    0);
        rst = 1'b0; bus.button = 1'b0;
        tick(2);

        // Hold four cycles, release with 5.
        bus.button = 1'b1;
        tick(4);
        bus.button = 1'b0; bus.throw = 3'd5;
        tick();
        check("p_result", int'(bus.result),       5);
        check("p_valid",  int'(bus.result_valid), 1);
        check("p_leds",   int'(bus.leds),         'h67);
        check("p_total",  int'(bus.total),        5);
        check("p_count",  int'(bus.roll_count),   1);
        check("p_double", int'(bus.double_flag),  0);
        tick();
        check("p_valid_drop", int'(bus.result_valid), 0);

        do_reset();
        roll(3'd2); roll(3'd2);
        check("dbl_flag",  int'(bus.double_flag), 1);
        check("dbl_total", int'(bus.total),       4);
        check("dbl_leds",  int'(bus.leds),        'h42);
        roll(3'd6);
        check("dbl_clear", int'(bus.double_flag), 0);

        do_reset();
        roll(3'd3);
        roll(3'd0);
        check("ill0_valid", int'(bus.result_valid), 0);
        roll(3'd7);
        check("ill_err",    int'(bus.err),        1);
        check("ill_result", int'(bus.result),     3);
        check("ill_total",  int'(bus.total),      3);
        check("ill_count",  int'(bus.roll_count), 1);
        roll(3'd4);
        check("err_sticky", int'(bus.err), 1);
        do_reset();
        check("err_cleared", int'(bus.err), 0);

        do_reset();
        repeat (42) roll(3'd6);
        check("sat_42", int'(bus.total), 252);
        roll(3'd6);
        check("sat_43",   int'(bus.total),      255);
        check("sat_cnt",  int'(bus.roll_count), 43);
        roll(3'd6);
        check("sat_44", int'(bus.total), 255);

        do_reset();
        repeat (256) roll(3'($urandom_range(1, 6)));
        check("wrap_cnt", int'(bus.roll_count), 0);

        do_reset();
        bus.button = 1'b1;
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.button = 1'b0; bus.throw = 3'd4;
        tick();
        check("rr_valid",  int'(bus.result_valid), 0);
        check("rr_result", int'(bus.result),       0);
        tick();
        check("rr_valid2", int'(bus.result_valid), 0);
        check("rr_count",  int'(bus.roll_count),   0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) bus.button = ~bus.button;
            if (bus.button) bus.throw = 3'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
